// File: rtl/icache_pkg.sv
// Shared types, constants and width helpers for the instruction cache.
package icache_pkg;

  // Controller states: lookup, line refill, one-cycle settle after the fill.
  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    REFILL    = 2'd1,
    FILL_DONE = 2'd2
  } state_t;

  // addi x0, x0, 0 -- handed to IF whenever no real instruction is available.
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  // Word-offset width inside a line.
  function automatic int offW(input int wordsPerLine);
    return $clog2(wordsPerLine);
  endfunction

  // Line-index width.
  function automatic int idxW(input int lines);
    return $clog2(lines);
  endfunction

  // Tag width: what remains above the byte, offset and index bits.
  function automatic int tagW(input int addrW, input int lines, input int wordsPerLine);
    return addrW - 2 - $clog2(lines) - $clog2(wordsPerLine);
  endfunction

endpackage

// File: rtl/icache_data_array.sv
// Flop-based instruction storage: combinational read, one synchronous write port.
module icache_data_array #(
  parameter int LINES          = 16,
  parameter int WORDS_PER_LINE = 4,
  parameter int IDX_W          = 4,
  parameter int OFF_W          = 2
) (
  input  logic             clk,
  input  logic             we,
  input  logic [IDX_W-1:0] wIdx,
  input  logic [OFF_W-1:0] wOff,
  input  logic [31:0]      wData,
  input  logic [IDX_W-1:0] rIdx,
  input  logic [OFF_W-1:0] rOff,
  output logic [31:0]      rData
);

  logic [31:0] words [LINES][WORDS_PER_LINE];

  // Refill beats land here one word at a time; contents need no reset.
  always_ff @(posedge clk) begin
    if (we) begin
      words[wIdx][wOff] <= wData;
    end
  end

  assign rData = words[rIdx][rOff];

endmodule

// File: rtl/icache_fetch.sv
// Direct-mapped read-only instruction cache for the IF stage.
// Hits return combinationally; a miss stalls IF and refills the whole line.
//
// Backing-memory handshake: mem_req_o and mem_addr_o are raised in REFILL and
// held unchanged until the memory pulses mem_ack_i; the cycle carrying
// mem_ack_i also carries the beat's data on mem_rdata_i. Acks seen in any
// other state are ignored.
module icache_fetch
  import icache_pkg::*;
#(
  parameter int LINES          = 16,
  parameter int WORDS_PER_LINE = 4,
  parameter int ADDR_W         = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] pc_i,
  input  logic              req_i,
  input  logic              flush_i,
  output logic [31:0]       instr_o,
  output logic              valid_o,
  output logic              stall_o,
  output logic              mem_req_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  input  logic [31:0]       mem_rdata_i,
  input  logic              mem_ack_i,
  output state_t            dbgState
);

  localparam int OFF_W = offW(WORDS_PER_LINE);
  localparam int IDX_W = idxW(LINES);
  localparam int TAG_W = tagW(ADDR_W, LINES, WORDS_PER_LINE);

  state_t state, nextState;

  logic [LINES-1:0] validBits;
  logic [TAG_W-1:0] tagArr [LINES];
  logic [TAG_W-1:0] missTag;
  logic [IDX_W-1:0] missIdx;
  logic [OFF_W-1:0] beat;
  logic             flushPending;

  logic [OFF_W-1:0] pcOff;
  logic [IDX_W-1:0] pcIdx;
  logic [TAG_W-1:0] pcTag;
  logic [1:0]       unusedPcBits;
  logic             lineHit;
  logic             hit;
  logic             lastBeat;
  logic             beatAck;
  logic [31:0]      rdData;

  assign pcOff        = pc_i[OFF_W+1:2];
  assign pcIdx        = pc_i[OFF_W+IDX_W+1:OFF_W+2];
  assign pcTag        = pc_i[ADDR_W-1:OFF_W+IDX_W+2];
  assign unusedPcBits = pc_i[1:0];

  // Hits only count in IDLE so a line being written never forwards early.
  assign lineHit  = validBits[pcIdx] && (tagArr[pcIdx] == pcTag);
  assign hit      = lineHit && (state == IDLE);
  assign lastBeat = (beat == OFF_W'(WORDS_PER_LINE - 1));
  assign beatAck  = (state == REFILL) && mem_ack_i;

  assign valid_o    = req_i && hit;
  assign stall_o    = req_i && !hit;
  assign instr_o    = valid_o ? rdData : NOP_INSTR;
  assign mem_req_o  = (state == REFILL);
  // Line base with the beat number in the offset field == base + 4*beat.
  assign mem_addr_o = (state == REFILL) ? {missTag, missIdx, beat, 2'b00} : '0;
  assign dbgState   = state;

  icache_data_array #(
    .LINES         (LINES),
    .WORDS_PER_LINE(WORDS_PER_LINE),
    .IDX_W         (IDX_W),
    .OFF_W         (OFF_W)
  ) u_data (
    .clk  (clk),
    .we   (beatAck),
    .wIdx (missIdx),
    .wOff (beat),
    .wData(mem_rdata_i),
    .rIdx (pcIdx),
    .rOff (pcOff),
    .rData(rdData)
  );

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= nextState;
    end
  end

  // Next-state: miss starts a refill, last acked beat settles for one cycle.
  always_comb begin
    nextState = state;
    case (state)
      IDLE:      if (req_i && !lineHit) nextState = REFILL;
      REFILL:    if (mem_ack_i && lastBeat) nextState = FILL_DONE;
      FILL_DONE: nextState = IDLE;
      default:   nextState = IDLE;
    endcase
  end

  // Valid bits, miss bookkeeping and deferred flush handling.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      validBits    <= '0;
      missTag      <= '0;
      missIdx      <= '0;
      beat         <= '0;
      flushPending <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (flush_i) begin
            validBits <= '0;
          end
          if (req_i && !lineHit) begin
            missTag <= pcTag;
            missIdx <= pcIdx;
            beat    <= '0;
          end
        end
        REFILL: begin
          if (flush_i) begin
            flushPending <= 1'b1;
          end
          if (mem_ack_i) begin
            beat <= beat + OFF_W'(1);
            if (lastBeat) begin
              // A flush seen at any point in the refill keeps the line invalid.
              validBits[missIdx] <= !(flushPending || flush_i);
            end
          end
        end
        FILL_DONE: begin
          if (flushPending || flush_i) begin
            validBits <= '0;
          end
          flushPending <= 1'b0;
        end
        default: begin
          flushPending <= 1'b0;
        end
      endcase
    end
  end

  // Tag written alongside the final beat; no reset needed behind the valid bits.
  always_ff @(posedge clk) begin
    if (beatAck && lastBeat) begin
      tagArr[missIdx] <= missTag;
    end
  end

endmodule

// File: tb/tb_icache_fetch.sv
// Directed plus randomized bench for icache_fetch against a line-level model.
module tb_icache_fetch;
  import icache_pkg::*;

  logic        clk;
  logic        rst;
  logic [31:0] pc_i;
  logic        req_i;
  logic        flush_i;
  logic [31:0] instr_o;
  logic        valid_o;
  logic        stall_o;
  logic        mem_req_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_rdata_i;
  logic        mem_ack_i;
  state_t      dbgState;

  int testCnt = 0;
  int failCnt = 0;

  // Reference model: which line holds which tag (16 lines, 16-byte lines).
  bit          mValid [16];
  logic [23:0] mTag   [16];

  icache_fetch #(
    .LINES         (16),
    .WORDS_PER_LINE(4),
    .ADDR_W        (32)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .pc_i       (pc_i),
    .req_i      (req_i),
    .flush_i    (flush_i),
    .instr_o    (instr_o),
    .valid_o    (valid_o),
    .stall_o    (stall_o),
    .mem_req_o  (mem_req_o),
    .mem_addr_o (mem_addr_o),
    .mem_rdata_i(mem_rdata_i),
    .mem_ack_i  (mem_ack_i),
    .dbgState   (dbgState)
  );

  // Clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Watchdog.
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, observed=timeout required=finish");
    $fatal(1, "watchdog");
  end

  // Backing memory contents: distinct word per address; 0x10..0x1C give 0xA0..0xA3.
  function automatic logic [31:0] memWord(input logic [31:0] a);
    return ((a >> 2) + 32'h9C) ^ {a[15:8], 24'h0};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    testCnt++;
    assert (obs === exp)
    else begin
      failCnt++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic modelClear();
    for (int i = 0; i < 16; i++) mValid[i] = 1'b0;
  endtask

  // One fetch of pc: a hit is checked in one cycle; a miss is walked through
  // its refill with ack latencies drawn from [minLat,maxLat]. flushBeat >= 0
  // raises flush_i on the first cycle of that beat; redirect swaps pc_i after beat 1 starts.
  task automatic fetch(input logic [31:0] pc, input int minLat, input int maxLat,
                       input int flushBeat, input bit redirect, input logic [31:0] newPc);
    int          idx;
    int          lat;
    bit          flushed;
    logic [31:0] base;
    idx     = int'(pc[7:4]);
    base    = {pc[31:4], 4'b0000};
    flushed = 1'b0;
    req_i = 1'b1; pc_i = pc; flush_i = 1'b0; mem_ack_i = 1'b0; mem_rdata_i = $urandom;
    #1;
    if (mValid[idx] && mTag[idx] == pc[31:8]) begin
      check("hit_valid", 32'(valid_o), 32'd1);
      check("hit_stall", 32'(stall_o), 32'd0);
      check("hit_instr", instr_o, memWord({pc[31:2], 2'b00}));
      check("hit_memreq", 32'(mem_req_o), 32'd0);
      step();
      return;
    end
    check("miss_valid", 32'(valid_o), 32'd0);
    check("miss_stall", 32'(stall_o), 32'd1);
    check("miss_instr", instr_o, NOP_INSTR);
    check("miss_memreq_idle", 32'(mem_req_o), 32'd0);
    step();
    for (int b = 0; b < 4; b++) begin
      lat = $urandom_range(maxLat, minLat);
      for (int k = 1; k <= lat; k++) begin
        mem_ack_i   = (k == lat);
        mem_rdata_i = mem_ack_i ? memWord(base + 32'(4 * b)) : $urandom;
        flush_i     = (b == flushBeat) && (k == 1);
        if (flush_i) flushed = 1'b1;
        if (redirect && b == 1 && k == 1) pc_i = newPc;
        #1;
        check("refill_memreq", 32'(mem_req_o), 32'd1);
        check("refill_addr", mem_addr_o, base + 32'(4 * b));
        check("refill_stall", 32'(stall_o), 32'd1);
        check("refill_valid", 32'(valid_o), 32'd0);
        step();
      end
    end
    mem_ack_i = 1'b0; flush_i = 1'b0; mem_rdata_i = $urandom;
    #1;
    check("done_stall", 32'(stall_o), 32'd1);
    check("done_memreq", 32'(mem_req_o), 32'd0);
    check("done_state", 32'(dbgState), 32'(FILL_DONE));
    step();
    if (flushed) begin
      modelClear();
    end else begin
      mValid[idx] = 1'b1;
      mTag[idx]   = pc[31:8];
    end
  endtask

  task automatic quickFetch(input logic [31:0] pc);
    fetch(pc, 1, 1, -1, 1'b0, 32'h0);
  endtask

  // Directed sequence followed by randomized fetch traffic.
  initial begin
    logic [31:0] rpc;
    modelClear();
    rst = 1'b0; req_i = 1'b0; pc_i = '0; flush_i = 1'b0; mem_ack_i = 1'b0; mem_rdata_i = '0;
    #2;
    check("rst_memreq", 32'(mem_req_o), 32'd0);
    check("rst_memaddr", mem_addr_o, 32'd0);
    check("rst_stall", 32'(stall_o), 32'd0);
    check("rst_valid", 32'(valid_o), 32'd0);
    check("rst_instr", instr_o, NOP_INSTR);
    check("rst_state", 32'(dbgState), 32'(IDLE));
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;

    // Idle with no request.
    #1;
    check("idle_stall", 32'(stall_o), 32'd0);
    check("idle_instr", instr_o, NOP_INSTR);
    check("idle_memreq", 32'(mem_req_o), 32'd0);
    step();

    // Cold miss then hit sweep.
    quickFetch(32'h10);
    quickFetch(32'h10);
    quickFetch(32'h14);
    quickFetch(32'h18);
    quickFetch(32'h1C);

    // Conflict eviction on index 1.
    quickFetch(32'h110);
    quickFetch(32'h110);
    quickFetch(32'h10);
    quickFetch(32'h10);

    // Slow memory: ack every third cycle.
    fetch(32'h200, 3, 3, -1, 1'b0, 32'h0);
    quickFetch(32'h204);

    // PC redirect while refilling.
    fetch(32'h520, 1, 2, -1, 1'b1, 32'h10);
    quickFetch(32'h10);
    quickFetch(32'h528);

    // Randomized traffic over three tags, four indices.
    for (int n = 0; n < 40; n++) begin
      rpc = {22'd0, 2'($urandom_range(2, 0)), 4'($urandom_range(3, 0)), 4'($urandom)};
      fetch(rpc, 1, 3, -1, 1'b0, 32'h0);
    end

    // Flush during beat 2 of a refill.
    quickFetch(32'h10);
    quickFetch(32'h10);
    fetch(32'h40, 1, 2, 2, 1'b0, 32'h0);
    quickFetch(32'h40);
    quickFetch(32'h10);
    quickFetch(32'h40);

    // Flush in IDLE with a stray ack that must be ignored.
    req_i = 1'b0; flush_i = 1'b1; mem_ack_i = 1'b1; mem_rdata_i = 32'hDEAD_BEEF;
    #1;
    check("idleflush_stall", 32'(stall_o), 32'd0);
    check("idleflush_memreq", 32'(mem_req_o), 32'd0);
    check("idleflush_instr", instr_o, NOP_INSTR);
    step();
    flush_i = 1'b0; mem_ack_i = 1'b0;
    modelClear();
    quickFetch(32'h44);
    quickFetch(32'h48);
    quickFetch(32'h110);

    // Async reset between acks of a refill.
    req_i = 1'b1; pc_i = 32'h300;
    #1;
    check("rstmid_stall0", 32'(stall_o), 32'd1);
    step();
    mem_ack_i = 1'b1; mem_rdata_i = memWord(32'h300);
    #1;
    check("rstmid_addr0", mem_addr_o, 32'h300);
    step();
    mem_ack_i = 1'b0;
    #1;
    check("rstmid_addr1", mem_addr_o, 32'h304);
    #2;
    rst = 1'b0;
    #1;
    check("rstmid_memreq", 32'(mem_req_o), 32'd0);
    check("rstmid_memaddr", mem_addr_o, 32'd0);
    check("rstmid_state", 32'(dbgState), 32'(IDLE));
    check("rstmid_stall", 32'(stall_o), 32'd1);
    step();
    rst = 1'b1;
    modelClear();
    quickFetch(32'h48);
    quickFetch(32'h110);
    quickFetch(32'h300);
    quickFetch(32'h30C);

    req_i = 1'b0;
    step();
    $display("[TB] %0d tests run, %0d failed", testCnt, failCnt);
    $finish;
  end

endmodule

// File: doc/icache_fetch.md
Name: icache_fetch

Overview:
- Direct-mapped, read-only instruction cache that supplies instructions to the IF stage of the pipelined core, in place of the combinational instruction memory.
- On a hit it returns the instruction combinationally, so timing matches the existing fetch path.
- On a miss it raises a stall that freezes the PC and the IF/ID register. It then refills the line from a backing instruction memory using a valid/ack handshake.

Parameters:
- LINES, 16, number of cache lines (power of 2, ≥2)
- WORDS_PER_LINE, 4, 32-bit words per line (power of 2, ≥2)
- ADDR_W, 32, byte address width

Ports:
- clk  in  1  core clock
- rst  in  1  reset, asynchronous, active-low
- pc_i  in  ADDR_W  fetch byte address (from PC register)
- req_i  in  1  fetch request this cycle
- flush_i  in  1  invalidate all lines (fence.i / program reload)
- instr_o  out  32  fetched instruction; NOP when not valid
- valid_o  out  1  instr_o is a real hit for pc_i this cycle
- stall_o  out  1  hold PC and IF/ID (PCWrite/IFIDWrite low)
- mem_req_o  out  1  backing-memory read request
- mem_addr_o  out  ADDR_W  word-aligned byte address of the beat being requested
- mem_rdata_i  in  32  backing-memory read data
- mem_ack_i  in  1  beat accepted; mem_rdata_i valid this cycle

Behaviour:
- Address split:
  - Bits [1:0] are ignored.
  - Offset is the next log2(WORDS_PER_LINE) bits; index is the next log2(LINES) bits; tag is the remainder.
  - With defaults: offset=pc[3:2], index=pc[7:4], tag=pc[31:8].
- Storage: per line, one valid bit, a tag and WORDS_PER_LINE data words, all in flops. Lookup is combinational.
- hit = valid[index] & (tag[index]==tag(pc_i)) & state==IDLE.
- valid_o = req_i & hit.
- instr_o = data word when valid_o, else 32'h0000_0013.
- stall_o = req_i & ~hit; asserted in every state other than IDLE whenever req_i=1.
- Reset (rst=0, async):
  - All valid bits clear; state=IDLE.
  - mem_req_o=0, mem_addr_o=0, beat counter=0, flush_pending=0.
  - Tag and data arrays need no reset.
- FSM states are IDLE, REFILL and FILL_DONE.
- IDLE:
  - req_i & ~hit: latch line base {tag,index,0} into miss_addr and set the beat counter to 0, then go to REFILL.
  - flush_i in IDLE: clear all valid bits at the next edge. If a miss starts on the same cycle, the refill proceeds; the flush applies first.
- REFILL:
  - mem_req_o=1 and mem_addr_o = miss_addr + 4*beat.
  - Request and address hold stable until mem_ack_i.
  - On each ack: write mem_rdata_i into data[miss_index][beat] and increment beat.
  - On the ack of beat WORDS_PER_LINE-1: write tag[miss_index], set valid[miss_index]=~flush_pending, go to FILL_DONE.
  - mem_req_o drops in the cycle after the final ack. There is no back-to-back request across lines.
- FILL_DONE:
  - One cycle with stall_o still asserted. This breaks the comb path from the array write to the hit.
  - If flush_pending: clear all valid bits and flush_pending.
  - Go to IDLE. The lookup re-evaluates against the current pc_i.
- flush_i during REFILL:
  - Set flush_pending. The handshake is never abandoned mid-line.
  - The refilled line is not marked valid, and all lines are invalidated in FILL_DONE.
- pc_i change during REFILL (e.g. an EX-stage redirect while IF is stalled):
  - The refill completes for the latched miss_addr. The new pc_i is looked up in IDLE and may miss again.
- req_i=0 in IDLE: no miss is started, stall_o=0, instr_o=NOP.
- mem_ack_i outside REFILL: ignored.
- Hit latency is 0 cycles.
- Miss penalty is (sum of ack latencies for WORDS_PER_LINE beats) + 1 cycle (FILL_DONE) + the cycle that enters REFILL.

Decomposition:
- Package icache_pkg:
  - state enum (IDLE, REFILL, FILL_DONE)
  - NOP_INSTR = 32'h0000_0013
  - derived widths OFF_W, IDX_W, TAG_W as functions of the parameters
- One sub-module, icache_data_array: LINES×WORDS_PER_LINE×32 flop array with a combinational read port (index, offset) and one synchronous write port (index, offset, data, we).
- Valid bits, tags and the FSM stay in icache_fetch.

Test Plan:
- Cold miss: reset, req_i=1, pc_i=0x0000_0010, memory acks every cycle with data 0xA0..0xA3.
  - Expect mem_addr_o 0x10, 0x14, 0x18, 0x1C and stall_o high for 6 cycles.
  - Then valid_o=1, instr_o=0xA0.
- Hit sweep: after the above, pc_i=0x14, 0x18, 0x1C on consecutive cycles.
  - Expect valid_o=1, stall_o=0, instr_o=0xA1, 0xA2, 0xA3, and no mem_req_o.
- Conflict eviction: fill pc 0x10, then request pc 0x110 (same index 1, tag 1).
  - Expect a refill from 0x110.
  - Re-requesting 0x10 must miss again.
- Slow memory: mem_ack_i every 3rd cycle.
  - mem_req_o and mem_addr_o must stay stable between acks.
  - Stall length is 4×3+2 cycles.
- Flush mid-refill: assert flush_i during beat 2.
  - The refill completes all 4 beats.
  - The same pc then misses again (line not valid); previously valid lines also miss.
- Async reset mid-REFILL: drop rst between acks.
  - mem_req_o=0 immediately, state IDLE.
  - All lines miss after release.
